// File: rtl/irb_read_arbiter.sv
// Round-robin arbiter that shares one external read channel between N_REQ requesters.
// One transaction is in flight at a time, guarded by a timeout, with sticky error flags.
module irb_read_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DW      = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_i,
    output logic [N_REQ-1:0]         rd_valid_o,
    output logic [DW-1:0]            rd_data_o,
    output logic                     mem_req_o,
    output logic [$clog2(N_REQ)-1:0] mem_id_o,
    input  logic                     mem_valid_i,
    input  logic [DW-1:0]            mem_data_i,
    output logic                     busy_o,
    input  logic                     err_clr_i,
    output logic                     err_timeout_o,
    output logic                     err_ovf_o,
    output logic                     err_spurious_o
);

    localparam int unsigned   IW        = $clog2(N_REQ);
    localparam int unsigned   TW        = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] LastInit  = IW'(N_REQ - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e           state_q;
    logic [N_REQ-1:0] pending_q;
    logic [N_REQ-1:0] pending_d;
    logic [N_REQ-1:0] clear_mask;
    logic [IW-1:0]    grant_q;
    logic [IW-1:0]    last_grant_q;
    logic [IW-1:0]    pick;
    logic [IW-1:0]    idx;
    logic             found;
    logic [TW-1:0]    timer_q;
    logic [DW-1:0]    data_q;
    logic [N_REQ-1:0] rd_valid_q;
    logic             mem_req_q;
    logic             busy_q;
    logic             err_timeout_q;
    logic             err_ovf_q;
    logic             err_spurious_q;
    logic             timeout_hit;
    logic             ovf_hit;
    logic             spurious_hit;

    // Cyclic search starting just after the last served requester.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            idx = IW'((32'(last_grant_q) + off) % N_REQ);
            if (!found && pending_q[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // A request for the granted index during ISSUE re-arms it rather than overflowing.
    always_comb begin
        clear_mask = '0;
        if (state_q == StIssue) begin
            clear_mask[grant_q] = 1'b1;
        end
        ovf_hit      = |(req_i & pending_q & ~clear_mask);
        pending_d    = (pending_q & ~clear_mask) | req_i;
        timeout_hit  = (state_q == StWait) && !mem_valid_i && (timer_q == TimerLast);
        spurious_hit = mem_valid_i && (state_q != StWait);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q      <= '0;
            err_timeout_q  <= 1'b0;
            err_ovf_q      <= 1'b0;
            err_spurious_q <= 1'b0;
        end else begin
            pending_q      <= pending_d;
            err_timeout_q  <= (err_timeout_q & ~err_clr_i) | timeout_hit;
            err_ovf_q      <= (err_ovf_q & ~err_clr_i) | ovf_hit;
            err_spurious_q <= (err_spurious_q & ~err_clr_i) | spurious_hit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= LastInit;
            timer_q      <= '0;
            data_q       <= '0;
            rd_valid_q   <= '0;
            mem_req_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            mem_req_q  <= 1'b0;
            rd_valid_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        grant_q   <= pick;
                        state_q   <= StIssue;
                        mem_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                StIssue: begin
                    timer_q <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (mem_valid_i) begin
                        data_q     <= mem_data_i;
                        rd_valid_q <= N_REQ'(1) << grant_q;
                        state_q    <= StResp;
                    end else if (timer_q == TimerLast) begin
                        data_q     <= '0;
                        rd_valid_q <= N_REQ'(1) << grant_q;
                        state_q    <= StResp;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                StResp: begin
                    last_grant_q <= grant_q;
                    state_q      <= StIdle;
                    busy_q       <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_valid_o     = rd_valid_q;
    assign rd_data_o      = data_q;
    assign mem_req_o      = mem_req_q;
    assign mem_id_o       = grant_q;
    assign busy_o         = busy_q;
    assign err_timeout_o  = err_timeout_q;
    assign err_ovf_o      = err_ovf_q;
    assign err_spurious_o = err_spurious_q;

endmodule

// File: tb/tb_irb_read_arbiter.sv
// Testbench for irb_read_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-phase reference model.
module tb_irb_read_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic          mem_valid = 1'b0;
    logic [DW-1:0] mem_data = '0;
    logic          err_clr = 1'b0;

    logic [N-1:0]  rd_valid_o;
    logic [DW-1:0] rd_data_o;
    logic          mem_req_o;
    logic [1:0]    mem_id_o;
    logic          busy_o;
    logic          err_timeout_o;
    logic          err_ovf_o;
    logic          err_spurious_o;

    int checks = 0;
    int errors = 0;

    // Memory responder controls.
    int            resp_lat  = 1;
    int            resp_cnt  = 0;
    bit            resp_rand = 1'b0;
    logic [DW-1:0] resp_word = '0;

    // Reference model: phase 0 idle, 1 issue, 2 wait, 3 respond.
    int            m_phase;
    int            m_last;
    int            m_gnt;
    int            m_wcnt;
    bit   [N-1:0]  m_pend;
    logic [DW-1:0] m_data;
    bit            m_to;
    bit            m_ovf;
    bit            m_sp;

    irb_read_arbiter #(
        .N_REQ   (N),
        .DW      (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req),
        .rd_valid_o     (rd_valid_o),
        .rd_data_o      (rd_data_o),
        .mem_req_o      (mem_req_o),
        .mem_id_o       (mem_id_o),
        .mem_valid_i    (mem_valid),
        .mem_data_i     (mem_data),
        .busy_o         (busy_o),
        .err_clr_i      (err_clr),
        .err_timeout_o  (err_timeout_o),
        .err_ovf_o      (err_ovf_o),
        .err_spurious_o (err_spurious_o)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void model_reset();
        m_phase = 0;
        m_last  = N - 1;
        m_gnt   = 0;
        m_wcnt  = 0;
        m_pend  = '0;
        m_data  = '0;
        m_to    = 1'b0;
        m_ovf   = 1'b0;
        m_sp    = 1'b0;
    endfunction

    function automatic void model_update();
        bit          ovf;
        bit          sp;
        bit          to;
        bit          hit;
        bit [N-1:0]  npend;
        ovf   = 1'b0;
        to    = 1'b0;
        sp    = mem_valid && (m_phase != 2);
        npend = m_pend;
        if (m_phase == 1) npend[m_gnt] = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                if (npend[i]) ovf = 1'b1;
                npend[i] = 1'b1;
            end
        end
        case (m_phase)
            0: begin
                hit = 1'b0;
                for (int j = 1; j <= N; j++) begin
                    if (!hit && m_pend[(m_last + j) % N]) begin
                        hit     = 1'b1;
                        m_gnt   = (m_last + j) % N;
                        m_phase = 1;
                    end
                end
            end
            1: begin
                m_wcnt  = 0;
                m_phase = 2;
            end
            2: begin
                if (mem_valid) begin
                    m_data  = mem_data;
                    m_phase = 3;
                end else if (m_wcnt == TO - 1) begin
                    to      = 1'b1;
                    m_data  = '0;
                    m_phase = 3;
                end else begin
                    m_wcnt++;
                end
            end
            default: begin
                m_last  = m_gnt;
                m_phase = 0;
            end
        endcase
        m_pend = npend;
        m_to   = (m_to && !err_clr) || to;
        m_ovf  = (m_ovf && !err_clr) || ovf;
        m_sp   = (m_sp && !err_clr) || sp;
    endfunction

    // Advance one clock; afterwards the bench sits 1 time unit into the new cycle.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_reset();
            resp_cnt = 0;
        end else begin
            model_update();
        end
        #1;
        req       = '0;
        err_clr   = 1'b0;
        mem_valid = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                mem_valid = 1'b1;
                mem_data  = resp_rand ? 16'($urandom) : resp_word;
            end
        end
        if (mem_req_o && !rst) begin
            if (resp_rand) resp_cnt = $urandom_range(1, 11);
            else if (resp_lat > 0) resp_cnt = resp_lat;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({rd_valid_o, rd_data_o, mem_req_o, mem_id_o, busy_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0",
                     {rd_valid_o, rd_data_o, mem_req_o, mem_id_o, busy_o});
        end
        checks++;
        if ({err_timeout_o, err_ovf_o, err_spurious_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b required 000",
                     {err_timeout_o, err_ovf_o, err_spurious_o});
        end
    endtask

    task automatic test_single();
        do_reset();
        resp_lat  = 1;
        resp_word = 16'hA5A5;
        req       = 4'b0010;
        tick();
        tick();
        checks++;
        if (mem_req_o !== 1'b1 || mem_id_o !== 2'd1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL single_issue: got req=%b id=%0d busy=%b required 1/1/1",
                     mem_req_o, mem_id_o, busy_o);
        end
        tick();
        checks++;
        if (busy_o !== 1'b1 || mem_req_o !== 1'b0 || rd_valid_o !== 4'b0000) begin
            errors++;
            $display("FAIL single_wait: got busy=%b req=%b valid=%b", busy_o, mem_req_o,
                     rd_valid_o);
        end
        tick();
        checks++;
        if (rd_valid_o !== 4'b0010 || rd_data_o !== 16'hA5A5 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL single_resp: got valid=%b data=%h busy=%b required 0010/a5a5/1",
                     rd_valid_o, rd_data_o, busy_o);
        end
        tick();
        checks++;
        if (rd_valid_o !== 4'b0000 || busy_o !== 1'b0 || rd_data_o !== 16'hA5A5) begin
            errors++;
            $display("FAIL single_idle: got valid=%b busy=%b data=%h", rd_valid_o, busy_o,
                     rd_data_o);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_v;
        do_reset();
        resp_lat  = 1;
        resp_word = 16'h3C3C;
        req       = 4'b1111;
        for (int c = 1; c <= 18; c++) begin
            tick();
            exp_v = (c % 4 == 0 && c >= 4 && c <= 16) ? 4'(1 << (c / 4 - 1)) : 4'b0000;
            checks++;
            if (rd_valid_o !== exp_v) begin
                errors++;
                $display("FAIL rr_valid cycle %0d: got %b required %b", c, rd_valid_o, exp_v);
            end
            if (c % 4 == 2 && c <= 14) begin
                checks++;
                if (mem_req_o !== 1'b1 || mem_id_o !== 2'(c / 4)) begin
                    errors++;
                    $display("FAIL rr_grant cycle %0d: got req=%b id=%0d required 1/%0d",
                             c, mem_req_o, mem_id_o, c / 4);
                end
            end
        end
        checks++;
        if ({err_timeout_o, err_ovf_o, err_spurious_o} !== 3'b000) begin
            errors++;
            $display("FAIL rr_flags: got %b required 000",
                     {err_timeout_o, err_ovf_o, err_spurious_o});
        end
    endtask

    task automatic test_fairness();
        int g[6];
        int n;
        do_reset();
        resp_lat = 1;
        n        = 0;
        req      = 4'b0101;
        for (int c = 1; c <= 80 && n < 6; c++) begin
            tick();
            if (mem_req_o) begin
                g[n] = int'(mem_id_o);
                n++;
            end
            if (rd_valid_o[0]) req[0] = 1'b1;
            if (rd_valid_o[2]) req[2] = 1'b1;
        end
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL fair_count: got %0d grants required 6", n);
        end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (g[k] != ((k % 2 == 0) ? 0 : 2)) begin
                errors++;
                $display("FAIL fair_order grant %0d: got %0d required %0d", k, g[k],
                         (k % 2 == 0) ? 0 : 2);
            end
        end
        checks++;
        if (err_ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL fair_ovf: got %b required 0", err_ovf_o);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        resp_lat  = 1;
        resp_word = 16'hBEEF;
        req       = 4'b0001;
        for (int c = 1; c <= 5; c++) tick();
        checks++;
        if (rd_data_o !== 16'hBEEF) begin
            errors++;
            $display("FAIL to_prior_data: got %h required beef", rd_data_o);
        end
        resp_lat = 0;
        req      = 4'b1000;
        for (int c = 1; c <= 10; c++) tick();
        checks++;
        if (err_timeout_o !== 1'b0 || busy_o !== 1'b1 || rd_valid_o !== 4'b0000) begin
            errors++;
            $display("FAIL to_last_wait: got to=%b busy=%b valid=%b required 0/1/0000",
                     err_timeout_o, busy_o, rd_valid_o);
        end
        tick();
        checks++;
        if (err_timeout_o !== 1'b1 || rd_valid_o !== 4'b1000 || rd_data_o !== 16'h0000) begin
            errors++;
            $display("FAIL to_resp: got to=%b valid=%b data=%h required 1/1000/0000",
                     err_timeout_o, rd_valid_o, rd_data_o);
        end
        tick();
        checks++;
        if (busy_o !== 1'b0 || err_spurious_o !== 1'b0) begin
            errors++;
            $display("FAIL to_idle: got busy=%b spur=%b required 0/0", busy_o, err_spurious_o);
        end
        mem_valid = 1'b1;
        mem_data  = 16'h7777;
        tick();
        checks++;
        if (err_spurious_o !== 1'b1 || rd_valid_o !== 4'b0000 || rd_data_o !== 16'h0000) begin
            errors++;
            $display("FAIL to_late: got spur=%b valid=%b data=%h required 1/0000/0000",
                     err_spurious_o, rd_valid_o, rd_data_o);
        end
    endtask

    task automatic test_overflow();
        int n0;
        int n3;
        do_reset();
        resp_lat = 3;
        req      = 4'b0001;
        tick();
        tick();
        req = 4'b1000;
        tick();
        checks++;
        if (err_ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_first: got %b required 0", err_ovf_o);
        end
        req = 4'b1000;
        tick();
        checks++;
        if (err_ovf_o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_second: got %b required 1", err_ovf_o);
        end
        n0 = 0;
        n3 = 0;
        for (int c = 0; c < 30; c++) begin
            if (rd_valid_o[0]) n0++;
            if (rd_valid_o[3]) n3++;
            tick();
        end
        checks++;
        if (n0 != 1 || n3 != 1) begin
            errors++;
            $display("FAIL ovf_served: got n0=%0d n3=%0d required 1/1", n0, n3);
        end
        err_clr = 1'b1;
        tick();
        checks++;
        if ({err_timeout_o, err_ovf_o, err_spurious_o} !== 3'b000) begin
            errors++;
            $display("FAIL ovf_clear: got %b required 000",
                     {err_timeout_o, err_ovf_o, err_spurious_o});
        end
        req     = 4'b0000;
        err_clr = 1'b1;
        mem_valid = 1'b1;
        tick();
        checks++;
        if (err_spurious_o !== 1'b1 || err_ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL set_beats_clear: got spur=%b ovf=%b required 1/0", err_spurious_o,
                     err_ovf_o);
        end
    endtask

    task automatic test_issue_collision();
        int n0;
        do_reset();
        resp_lat = 1;
        req      = 4'b0001;
        tick();
        tick();
        checks++;
        if (mem_req_o !== 1'b1 || mem_id_o !== 2'd0) begin
            errors++;
            $display("FAIL coll_issue: got req=%b id=%0d required 1/0", mem_req_o, mem_id_o);
        end
        req = 4'b0001;
        n0  = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (rd_valid_o[0]) n0++;
        end
        checks++;
        if (n0 != 2 || err_ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL coll_served: got n0=%0d ovf=%b required 2/0", n0, err_ovf_o);
        end
    endtask

    task automatic test_reset_wait();
        int bad;
        do_reset();
        resp_lat = 0;
        req      = 4'b0011;
        for (int c = 1; c <= 4; c++) tick();
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL rw_pre_busy: got %b required 1", busy_o);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({rd_valid_o, rd_data_o, mem_req_o, mem_id_o, busy_o,
             err_timeout_o, err_ovf_o, err_spurious_o} !== '0) begin
            errors++;
            $display("FAIL rw_async: got busy=%b req=%b id=%0d valid=%b data=%h",
                     busy_o, mem_req_o, mem_id_o, rd_valid_o, rd_data_o);
        end
        tick();
        tick();
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (rd_valid_o !== 4'b0000 || mem_req_o !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rw_quiet: got %0d active cycles required 0", bad);
        end
        resp_lat  = 1;
        resp_word = 16'h1234;
        req       = 4'b0100;
        tick();
        tick();
        checks++;
        if (mem_req_o !== 1'b1 || mem_id_o !== 2'd2) begin
            errors++;
            $display("FAIL rw_reissue: got req=%b id=%0d required 1/2", mem_req_o, mem_id_o);
        end
        tick();
        tick();
        checks++;
        if (rd_valid_o !== 4'b0100 || rd_data_o !== 16'h1234) begin
            errors++;
            $display("FAIL rw_resp: got valid=%b data=%h required 0100/1234", rd_valid_o,
                     rd_data_o);
        end
    endtask

    task automatic test_random();
        logic [26:0] obs;
        logic [26:0] exp;
        do_reset();
        resp_rand = 1'b1;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 2) == 0) req = 4'($urandom);
            if ($urandom_range(0, 40) == 0) err_clr = 1'b1;
            if ($urandom_range(0, 60) == 0) begin
                mem_valid = 1'b1;
                mem_data  = 16'($urandom);
            end
            tick();
            exp = {m_phase == 1, 2'(m_gnt), (m_phase == 3) ? 4'(1 << m_gnt) : 4'b0000,
                   m_data, m_phase != 0, m_to, m_ovf, m_sp};
            obs = {mem_req_o, mem_id_o, rd_valid_o, rd_data_o, busy_o,
                   err_timeout_o, err_ovf_o, err_spurious_o};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random cycle %0d: got %h required %h", c, obs, exp);
            end
        end
        resp_rand = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_timeout();
        test_overflow();
        test_issue_collision();
        test_reset_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
